// File: rtl/eth_pkg.sv
// ---------------------------------------------------------------------------
// eth_pkg
// Shared Ethernet constants for the GMII transmit path.
//   ETH_PREAMBLE / ETH_SFD   : line bytes sent ahead of every frame
//   CRC32_INIT               : CRC register value at the start of a frame
//   CRC32_RESIDUE            : register value after running payload + FCS
//   CRC32_POLY_REFL          : 0x04C11DB7 bit-reversed for LSB-first update
//   tx_state_t               : TX framer state encoding
// ---------------------------------------------------------------------------
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_PRE,
    TX_SFD,
    TX_DATA,
    TX_PAD,
    TX_FCS,
    TX_IFG
  } tx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// ---------------------------------------------------------------------------
// crc32_d8
// Combinational next-state function of the Ethernet CRC-32, one byte per
// call, reflected (LSB-first) form. The CRC register lives in the caller.
//   crc_in  [31:0] : current CRC register
//   data    [7:0]  : byte to absorb
//   crc_out [31:0] : CRC register after absorbing data
// ---------------------------------------------------------------------------
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // Fold the byte into the low bits, then shift out eight bits, applying
  // the reflected polynomial whenever a one falls off the bottom.
  always_comb begin
    logic [31:0] c;
    c = crc_in ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = (c >> 1) ^ CRC32_POLY_REFL;
      else      c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_tx_framer.sv
// ---------------------------------------------------------------------------
// gmii_tx_framer
// Turns a valid/ready/last byte stream into a complete GMII frame:
// preamble, SFD, payload, zero pad up to MIN_FRAME, CRC-32 FCS, then an
// enforced inter-frame gap of IFG_BYTES idle cycles.
//   gmii_tx_clk        : transmit clock, all logic on the rising edge
//   rst_n              : asynchronous active-low reset
//   s_tvalid/s_tdata/s_tlast/s_tready : upstream byte stream
//   gmii_tx_en/gmii_txd: registered GMII outputs to the RGMII stage
//   busy               : high whenever the framer is not idle
//   underrun           : one-cycle pulse when upstream starves mid-payload
// The state register names the byte being produced for the NEXT cycle, so
// DATA is entered while the SFD is still being prepared and s_tready can
// accept payload byte 0 in the same cycle the SFD is on the wire.
// ---------------------------------------------------------------------------
module gmii_tx_framer
  import eth_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_BYTES    = 12
)(
  input  logic       gmii_tx_clk,
  input  logic       rst_n,
  input  logic       s_tvalid,
  input  logic [7:0] s_tdata,
  input  logic       s_tlast,
  output logic       s_tready,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       busy,
  output logic       underrun
);

  localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);
  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);

  tx_state_t   state;
  logic [10:0] byte_cnt;
  logic [10:0] byte_cnt_inc;
  logic [7:0]  step_cnt;
  logic [31:0] crc;
  logic [31:0] crc_next;
  logic [7:0]  crc_data;
  logic [31:0] fcs_word;

  assign s_tready = (state == TX_DATA);

  // Pad bytes are zero, so the CRC input only follows s_tdata in DATA.
  assign crc_data = (state == TX_DATA) ? s_tdata : 8'h00;

  // Saturating payload count: only the pad decision depends on it.
  assign byte_cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;

  // FCS is the inverted register, least-significant byte first.
  assign fcs_word = ~crc >> {step_cnt[1:0], 3'b000};

  crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (crc_data),
    .crc_out (crc_next)
  );

  // Framer FSM with every output registered.
  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= TX_IDLE;
      gmii_tx_en <= 1'b0;
      gmii_txd   <= 8'h00;
      busy       <= 1'b0;
      underrun   <= 1'b0;
      byte_cnt   <= 11'd0;
      step_cnt   <= 8'd0;
      crc        <= CRC32_INIT;
    end else begin
      underrun <= 1'b0;
      case (state)
        TX_IDLE: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= 8'h00;
          busy       <= 1'b0;
          if (s_tvalid) begin
            gmii_tx_en <= 1'b1;
            gmii_txd   <= ETH_PREAMBLE;
            busy       <= 1'b1;
            step_cnt   <= 8'd1;
            state      <= (PRE_LAST == 8'd0) ? TX_SFD : TX_PRE;
          end
        end
        TX_PRE: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= ETH_PREAMBLE;
          if (step_cnt == PRE_LAST) state <= TX_SFD;
          else                      step_cnt <= step_cnt + 8'd1;
        end
        TX_SFD: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= ETH_SFD;
          crc        <= CRC32_INIT;
          byte_cnt   <= 11'd0;
          state      <= TX_DATA;
        end
        TX_DATA: begin
          if (s_tvalid) begin
            gmii_tx_en <= 1'b1;
            gmii_txd   <= s_tdata;
            crc        <= crc_next;
            byte_cnt   <= byte_cnt_inc;
            if (s_tlast) begin
              step_cnt <= 8'd0;
              state    <= (byte_cnt_inc < MIN_CNT) ? TX_PAD : TX_FCS;
            end
          end else begin
            // Starved mid-payload: drop the frame without an FCS. The idle
            // cycle produced here already counts toward the gap.
            underrun   <= 1'b1;
            gmii_tx_en <= 1'b0;
            gmii_txd   <= 8'h00;
            step_cnt   <= 8'd1;
            state      <= TX_IFG;
          end
        end
        TX_PAD: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= 8'h00;
          crc        <= crc_next;
          byte_cnt   <= byte_cnt_inc;
          if (byte_cnt_inc >= MIN_CNT) begin
            step_cnt <= 8'd0;
            state    <= TX_FCS;
          end
        end
        TX_FCS: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= fcs_word[7:0];
          if (step_cnt == 8'd3) begin
            step_cnt <= 8'd0;
            state    <= TX_IFG;
          end else begin
            step_cnt <= step_cnt + 8'd1;
          end
        end
        TX_IFG: begin
          // step_cnt counts idle cycles already produced; the last one is
          // on the wire while the FSM sits in IDLE.
          gmii_tx_en <= 1'b0;
          gmii_txd   <= 8'h00;
          if (step_cnt == IFG_LAST) begin
            busy  <= 1'b0;
            state <= TX_IDLE;
          end else begin
            step_cnt <= step_cnt + 8'd1;
          end
        end
        default: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= 8'h00;
          busy       <= 1'b0;
          state      <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_gmii_tx_framer
// Randomised frames are driven upstream; each frame's expected wire image
// (preamble, SFD, payload, pad, FCS) is built from the framing rules and
// queued. A monitor on the falling edge pops and compares every transmitted
// byte, frame length, gap length, underrun flag and CRC residue.
// ---------------------------------------------------------------------------
module tb_gmii_tx_framer;
  import eth_pkg::*;

  localparam int PRE  = 7;
  localparam int MINF = 60;
  localparam int IFG  = 12;

  logic       gmii_tx_clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       s_tvalid = 1'b0;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tlast = 1'b0;
  logic       s_tready;
  logic       gmii_tx_en;
  logic [7:0] gmii_txd;
  logic       busy;
  logic       underrun;

  logic [31:0] ut_crc_in = 32'hFFFFFFFF;
  logic [7:0]  ut_data = 8'h00;
  logic [31:0] ut_crc_out;

  always #4 gmii_tx_clk = ~gmii_tx_clk;

  gmii_tx_framer #(.PREAMBLE_LEN(PRE), .MIN_FRAME(MINF), .IFG_BYTES(IFG)) dut (
    .gmii_tx_clk (gmii_tx_clk),
    .rst_n       (rst_n),
    .s_tvalid    (s_tvalid),
    .s_tdata     (s_tdata),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_txd    (gmii_txd),
    .busy        (busy),
    .underrun    (underrun)
  );

  crc32_d8 u_crc_unit (
    .crc_in  (ut_crc_in),
    .data    (ut_data),
    .crc_out (ut_crc_out)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_bytes[$];
  int         exp_len[$];
  bit         exp_urun[$];
  int         urun_expected = 0;
  int         urun_seen = 0;
  bit         b2b = 1'b0;

  // Monitor state
  logic [7:0] rx_frame[$];
  int         rx_cnt = 0;
  bit         in_frame = 1'b0;
  bit         have_prev = 1'b0;
  int         gap = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Textbook bit-serial Ethernet CRC register (not inverted).
  function automatic logic [31:0] crcModel(input logic [7:0] bytes[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (bytes[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ bytes[i][b];
        c  = {1'b0, c[31:1]};
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  // Queue the expected wire image of one frame and drive it upstream.
  // drop_at >= 0 withdraws s_tvalid before that payload byte.
  task automatic applyStimulus(input int n, input int drop_at, input bit incr, input bit hold);
    logic [7:0]  pl[$];
    logic [7:0]  body[$];
    logic [31:0] fcs;
    int          sent;
    int          budget;
    int          limit;
    bit          rdy;
    for (int i = 0; i < n; i++)
      pl.push_back(incr ? 8'(i) : 8'($urandom_range(0, 255)));
    for (int i = 0; i < PRE; i++) exp_bytes.push_back(8'h55);
    exp_bytes.push_back(8'hD5);
    if (drop_at >= 0) begin
      for (int i = 0; i < drop_at; i++) exp_bytes.push_back(pl[i]);
      exp_len.push_back(PRE + 1 + drop_at);
      exp_urun.push_back(1'b1);
      urun_expected++;
      limit = drop_at;
    end else begin
      body = pl;
      while (body.size() < MINF) body.push_back(8'h00);
      fcs = ~crcModel(body);
      foreach (body[i]) exp_bytes.push_back(body[i]);
      for (int k = 0; k < 4; k++) exp_bytes.push_back(fcs[8*k +: 8]);
      exp_len.push_back(PRE + 1 + body.size() + 4);
      exp_urun.push_back(1'b0);
      limit = n;
    end
    sent = 0;
    budget = 0;
    while (sent < limit && budget < 4000) begin
      @(negedge gmii_tx_clk);
      s_tvalid = 1'b1;
      s_tdata  = pl[sent];
      s_tlast  = (drop_at < 0) && (sent == n - 1);
      rdy      = s_tready;
      @(posedge gmii_tx_clk);
      if (rdy) sent++;
      budget++;
    end
    if (sent != limit) checkOutput("driver_timeout", 32'(sent), 32'(limit));
    if (drop_at >= 0 || !hold) begin
      @(negedge gmii_tx_clk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    logic [7:0] body[$];
    int         l;
    bit         u;
    forever begin
      @(negedge gmii_tx_clk);
      if (underrun === 1'b1) urun_seen++;
      if (!rst_n) begin
        if (in_frame && exp_len.size() > 0) begin
          l = exp_len.pop_front();
          void'(exp_urun.pop_front());
          for (int i = rx_cnt; i < l && exp_bytes.size() > 0; i++) void'(exp_bytes.pop_front());
        end
        in_frame  = 1'b0;
        have_prev = 1'b0;
        rx_cnt    = 0;
        rx_frame.delete();
      end else if (gmii_tx_en === 1'b1) begin
        if (!in_frame) begin
          if (have_prev) begin
            if (gap < IFG) checkOutput("ifg_min", 32'(gap), 32'(IFG));
            if (b2b) checkOutput("ifg_b2b", 32'(gap), 32'(IFG));
          end
          if (exp_len.size() == 0) checkOutput("unexpected_frame", 32'(1), 32'(0));
          in_frame = 1'b1;
          rx_cnt   = 0;
          rx_frame.delete();
        end
        checkOutput("busy_in_frame", 32'(busy), 32'(1));
        if (exp_bytes.size() > 0 && exp_len.size() > 0 && rx_cnt < exp_len[0])
          checkOutput("txd_byte", 32'(gmii_txd), 32'(exp_bytes.pop_front()));
        else
          checkOutput("frame_overrun", 32'(rx_cnt), 32'(exp_len.size() > 0 ? exp_len[0] : 0));
        rx_frame.push_back(gmii_txd);
        rx_cnt++;
      end else begin
        if (in_frame) begin
          l = (exp_len.size() > 0) ? exp_len.pop_front() : -1;
          u = (exp_urun.size() > 0) ? exp_urun.pop_front() : 1'b0;
          checkOutput("frame_len", 32'(rx_cnt), 32'(l));
          checkOutput("underrun_flag", 32'(underrun), 32'(u));
          checkOutput("idle_txd", 32'(gmii_txd), 32'(0));
          if (!u) begin
            body.delete();
            for (int i = PRE + 1; i < rx_frame.size(); i++) body.push_back(rx_frame[i]);
            checkOutput("crc_residue", crcModel(body), CRC32_RESIDUE);
          end
          in_frame  = 1'b0;
          have_prev = 1'b1;
          gap       = 1;
        end else begin
          gap++;
        end
      end
    end
  end

  initial begin
    logic [7:0] digits[9];
    int         wait_cnt;
    digits = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    // CRC unit: "123456789" -> 0xCBF43926
    for (int i = 0; i < 9; i++) begin
      ut_data = digits[i];
      #1;
      ut_crc_in = ut_crc_out;
    end
    #1;
    checkOutput("crc_unit_check", ~ut_crc_in, 32'hCBF43926);

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_tx_en",    32'(gmii_tx_en), 32'(0));
    checkOutput("reset_txd",      32'(gmii_txd),   32'(0));
    checkOutput("reset_tready",   32'(s_tready),   32'(0));
    checkOutput("reset_busy",     32'(busy),       32'(0));
    checkOutput("reset_underrun", 32'(underrun),   32'(0));
    repeat (3) @(negedge gmii_tx_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge gmii_tx_clk);

    // 64-byte incrementing payload, then minimum-length boundary cases
    applyStimulus(64, -1, 1'b1, 1'b0);
    repeat (20) @(negedge gmii_tx_clk);
    applyStimulus(10, -1, 1'b0, 1'b0);
    repeat (15) @(negedge gmii_tx_clk);
    applyStimulus(60, -1, 1'b0, 1'b0);
    repeat (15) @(negedge gmii_tx_clk);
    applyStimulus(59, -1, 1'b0, 1'b0);
    repeat (15) @(negedge gmii_tx_clk);
    applyStimulus(61, -1, 1'b0, 1'b0);
    repeat (15) @(negedge gmii_tx_clk);
    applyStimulus(1, -1, 1'b0, 1'b0);
    repeat (15) @(negedge gmii_tx_clk);

    // Underrun at byte 20, with the next frame queued during the gap
    applyStimulus(40, 20, 1'b0, 1'b0);
    b2b = 1'b1;
    applyStimulus(30, -1, 1'b0, 1'b1);
    applyStimulus(70, -1, 1'b0, 1'b0);
    b2b = 1'b0;
    repeat (20) @(negedge gmii_tx_clk);

    // Randomised frames with random spacing
    for (int f = 0; f < 10; f++) begin
      applyStimulus($urandom_range(1, 100), -1, 1'b0, 1'b0);
      repeat ($urandom_range(0, 30)) @(negedge gmii_tx_clk);
    end
    repeat (20) @(negedge gmii_tx_clk);

    // Reset while the second FCS byte is on the wire
    applyStimulus(20, -1, 1'b0, 1'b0);
    wait_cnt = 0;
    while (rx_cnt != PRE + 1 + MINF + 1 && wait_cnt < 500) begin
      @(posedge gmii_tx_clk);
      #2;
      wait_cnt++;
    end
    if (wait_cnt >= 500) checkOutput("fcs_wait_timeout", 32'(rx_cnt), 32'(PRE + 1 + MINF + 1));
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_tx_en", 32'(gmii_tx_en), 32'(0));
    checkOutput("midreset_txd",   32'(gmii_txd),   32'(0));
    checkOutput("midreset_busy",  32'(busy),       32'(0));
    repeat (3) @(negedge gmii_tx_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge gmii_tx_clk);
    applyStimulus($urandom_range(1, 80), -1, 1'b0, 1'b0);

    // Drain the scoreboard
    wait_cnt = 0;
    while ((exp_len.size() > 0 || in_frame) && wait_cnt < 3000) begin
      @(negedge gmii_tx_clk);
      wait_cnt++;
    end
    checkOutput("drain_pending", 32'(exp_len.size()), 32'(0));
    repeat (5) @(negedge gmii_tx_clk);
    checkOutput("underrun_pulses", 32'(urun_seen), 32'(urun_expected));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
